nios_custom_dma_dp_ram: RTL and testbench

- Parametrised true dual-port on-chip RAM for the custom DMA subsystem; successor to the fixed 1K x 32 single-port buffer RAMs.
- Port s1 serves the Nios II data master; port s2 serves the DMA engine. Both ports are Avalon-MM slaves with pipelined reads (readdatavalid) and a configurable read latency.
- Adds behaviour the single-port buffer lacks: defined cross-port collision handling, out-of-range protection, and waitrequest-based stall while clken is low or reset_req is high.

---
 rtl/nios_custom_dma_dp_ram_if.sv | 28 ++
 rtl/nios_custom_dma_dp_ram.sv | 123 ++++++++++++
 tb/tb_nios_custom_dma_dp_ram.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/nios_custom_dma_dp_ram_if.sv
// Avalon-MM slave port bundle for the dual-port DMA buffer RAM.
// One instance per port; the RAM side uses the slave modport.
interface nios_custom_dma_dp_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, chipselect, read, write,
    output byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write,
    input  byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/nios_custom_dma_dp_ram.sv
// True dual-port DMA buffer RAM, pipelined Avalon reads, s1 write priority.
// NIOS_CUSTOM_DMA_DP_RAM_BYPASS_EN: forward cross-port writes to readers.
module nios_custom_dma_dp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clken,
  input  logic reset_req,
  nios_custom_dma_dp_ram_if.slave s1,
  nios_custom_dma_dp_ram_if.slave s2
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DATA_W-1:0] word_t;

  logic                   en;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][BE_W-1:0]   be;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0]             cs;
  logic [1:0]             rreq;
  logic [1:0]             wreq;
  logic [1:0]             inr;
  logic [1:0]             wr;
  logic [1:0]             rd;
  logic [1:0]             rv;
  logic [1:0][DATA_W-1:0] rq;

  word_t mem [DEPTH];

  assign en = clken & ~reset_req;

  assign s1.waitrequest = ~en;
  assign s2.waitrequest = ~en;

  assign addr  = {s2.address, s1.address};
  assign be    = {s2.byteenable, s1.byteenable};
  assign wdata = {s2.writedata, s1.writedata};
  assign cs    = {s2.chipselect, s1.chipselect};
  assign rreq  = {s2.read, s1.read};
  assign wreq  = {s2.write, s1.write};

  assign s1.readdata      = rq[0];
  assign s1.readdatavalid = rv[0];
  assign s2.readdata      = rq[1];
  assign s2.readdatavalid = rv[1];

  // Lanes written by both ports in one cycle keep the s1 byte.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wr[1] && be[1][i] &&
          !(wr[0] && be[0][i] && addr[0] == addr[1]))
        mem[addr[1][IDX_W-1:0]][i*8 +: 8] <= wdata[1][i*8 +: 8];
      if (wr[0] && be[0][i])
        mem[addr[0][IDX_W-1:0]][i*8 +: 8] <= wdata[0][i*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    word_t rdata;
    logic  v1;
    word_t q1;

    assign inr[p] = {1'b0, addr[p]} < (ADDR_W+1)'(DEPTH);
    assign wr[p]  = cs[p] & en & wreq[p] & inr[p];
    assign rd[p]  = cs[p] & en & rreq[p] & ~wreq[p];

    always_comb begin
      rdata = '0;
      if (inr[p]) begin
        rdata = mem[addr[p][IDX_W-1:0]];
`ifdef NIOS_CUSTOM_DMA_DP_RAM_BYPASS_EN
        if (wr[1-p] && addr[1-p] == addr[p]) begin
          for (int i = 0; i < BE_W; i++) begin
            if (be[1-p][i])
              rdata[i*8 +: 8] = wdata[1-p][i*8 +: 8];
          end
        end
`endif
      end
    end

    // Stage data only moves on accepted results so it holds between valids.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v1 <= 1'b0;
        q1 <= '0;
      end else if (en) begin
        v1 <= rd[p];
        if (rd[p])
          q1 <= rdata;
      end
    end

    if (RD_LAT == 2) begin : g_lat2
      logic  v2;
      word_t q2;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v2 <= 1'b0;
          q2 <= '0;
        end else if (en) begin
          v2 <= v1;
          if (v1)
            q2 <= q1;
        end
      end

      assign rv[p] = v2;
      assign rq[p] = q2;
    end else begin : g_lat1
      assign rv[p] = v1;
      assign rq[p] = q1;
    end
  end

endmodule

// File: tb/tb_nios_custom_dma_dp_ram.sv
// Scoreboard bench for nios_custom_dma_dp_ram at RD_LAT 1 and 2.
// Both instances see identical stimulus; expectations come from a model.
module tb_nios_custom_dma_dp_ram;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   d;
  } req_t;

  typedef struct {
    logic [31:0] d;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clken = 1'b1;
  logic reset_req = 1'b0;

  always #5 clk = ~clk;

  nios_custom_dma_dp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) a1 ();
  nios_custom_dma_dp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) a2 ();
  nios_custom_dma_dp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  nios_custom_dma_dp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();

  nios_custom_dma_dp_ram #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)
  ) u_lat1 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .reset_req(reset_req), .s1(a1), .s2(a2)
  );

  nios_custom_dma_dp_ram #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2)
  ) u_lat2 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .reset_req(reset_req), .s1(b1), .s2(b2)
  );

  logic [31:0] model [DEPTH];
  exp_t        exq [4][$];
  req_t        r [2];
  logic        ck = 1'b1;
  logic        rr = 1'b0;
  int unsigned ecnt = 0;
  logic        en_q = 1'b0;
  int          ntest = 0;
  int          nfail = 0;
  string       pn [4] = '{"l1_s1", "l1_s2", "l2_s1", "l2_s2"};

  always @(posedge clk) begin
    en_q <= clken & ~reset_req;
    if (clken && !reset_req)
      ecnt <= ecnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    if (!reset_n || !v || !en_q)
      return;
    if (exq[p].size() == 0) begin
      check({pn[p], "_extra_valid"}, 32'(v), 32'd0);
    end else begin
      e = exq[p].pop_front();
      check({pn[p], "_data"}, d, e.d);
      check({pn[p], "_latency"}, ecnt, e.due);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a1.readdatavalid, a1.readdata);
    mon(1, a2.readdatavalid, a2.readdata);
    mon(2, b1.readdatavalid, b1.readdata);
    mon(3, b2.readdatavalid, b2.readdata);
  end

  task automatic apply();
    a1.chipselect = r[0].cs; b1.chipselect = r[0].cs;
    a1.read       = r[0].rd; b1.read       = r[0].rd;
    a1.write      = r[0].wr; b1.write      = r[0].wr;
    a1.address    = r[0].a;  b1.address    = r[0].a;
    a1.byteenable = r[0].be; b1.byteenable = r[0].be;
    a1.writedata  = r[0].d;  b1.writedata  = r[0].d;
    a2.chipselect = r[1].cs; b2.chipselect = r[1].cs;
    a2.read       = r[1].rd; b2.read       = r[1].rd;
    a2.write      = r[1].wr; b2.write      = r[1].wr;
    a2.address    = r[1].a;  b2.address    = r[1].a;
    a2.byteenable = r[1].be; b2.byteenable = r[1].be;
    a2.writedata  = r[1].d;  b2.writedata  = r[1].d;
    clken     = ck;
    reset_req = rr;
  endtask

  task automatic model_step();
    logic [31:0] x;
    logic        in [2];
    int          o;
    if (!(ck && !rr && reset_n))
      return;
    for (int p = 0; p < 2; p++)
      in[p] = r[p].a < AW'(DEPTH);
    for (int p = 0; p < 2; p++) begin
      if (r[p].cs && r[p].rd && !r[p].wr) begin
        x = in[p] ? model[r[p].a[9:0]] : 32'd0;
        o = 1 - p;
`ifdef NIOS_CUSTOM_DMA_DP_RAM_BYPASS_EN
        if (in[p] && in[o] && r[o].cs && r[o].wr && r[o].a == r[p].a)
          for (int i = 0; i < 4; i++)
            if (r[o].be[i])
              x[i*8 +: 8] = r[o].d[i*8 +: 8];
`endif
        exq[p].push_back('{x, ecnt + 1});
        exq[p+2].push_back('{x, ecnt + 2});
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (r[p].cs && r[p].wr && in[p])
        for (int i = 0; i < 4; i++)
          if (r[p].be[i])
            model[r[p].a[9:0]][i*8 +: 8] = r[p].d[i*8 +: 8];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    apply();
    model_step();
    #1;
    check("l1_waitreq", 32'(a1.waitrequest), 32'(!(ck && !rr)));
    check("l2_waitreq", 32'(b2.waitrequest), 32'(!(ck && !rr)));
    r[0] = '0;
    r[1] = '0;
    ck = 1'b1;
    rr = 1'b0;
  endtask

  task automatic wr(input int p, input int a,
                    input logic [31:0] d, input logic [3:0] be);
    r[p] = '{cs: 1'b1, rd: 1'b0, wr: 1'b1, a: AW'(a), be: be, d: d};
  endtask

  task automatic rd(input int p, input int a);
    r[p] = '{cs: 1'b1, rd: 1'b1, wr: 1'b0, a: AW'(a), be: 4'hF, d: 32'd0};
  endtask

  task automatic rst_chk(input string tag);
    check({tag, "_l1s1_v"}, 32'(a1.readdatavalid), 32'd0);
    check({tag, "_l1s2_d"}, a2.readdata, 32'd0);
    check({tag, "_l2s1_v"}, 32'(b1.readdatavalid), 32'd0);
    check({tag, "_l2s2_d"}, b2.readdata, 32'd0);
  endtask

  initial begin
    r[0] = '0;
    r[1] = '0;
    apply();
    repeat (3) @(negedge clk);
    rst_chk("reset");
    reset_n = 1'b1;

    wr(0, 5, 32'hDEADBEEF, 4'hF); tick();
    rd(0, 5); tick();
    repeat (3) tick();

    wr(0, 7, 32'h11223344, 4'hF); tick();
    wr(1, 7, 32'hAABBCCDD, 4'h5); tick();
    rd(0, 7); tick();

    wr(0, 3, 32'h000000FF, 4'h3);
    wr(1, 3, 32'hFFFF0000, 4'hF); tick();
    rd(0, 3); rd(1, 3); tick();

    wr(0, 9, 32'h00000000, 4'hF); tick();
    wr(0, 9, 32'h12345678, 4'hF); rd(1, 9); tick();
    wr(1, 9, 32'hA5A5A5A5, 4'hC); rd(0, 9); tick();
    rd(0, 9); tick();
    repeat (3) tick();

    wr(0, 0, 32'h0A0A0A0A, 4'hF); wr(1, 1, 32'h1B1B1B1B, 4'hF); tick();
    wr(0, 2, 32'h2C2C2C2C, 4'hF); wr(1, 3, 32'h3D3D3D3D, 4'hF); tick();
    rd(1, 0); tick();
    rd(1, 1); tick();
    ck = 1'b0; rd(1, 2); tick();
    ck = 1'b0; rd(1, 2); tick();
    rd(1, 2); tick();
    rd(1, 3); tick();
    rr = 1'b1; rd(1, 0); tick();
    rd(1, 0); tick();
    repeat (4) tick();

    rd(0, 5); rd(1, 7); tick();
    @(posedge clk);
    #1 reset_n = 1'b0;
    apply();
    for (int p = 0; p < 4; p++)
      exq[p].delete();
    repeat (2) @(negedge clk);
    rst_chk("midrst");
    reset_n = 1'b1;
    repeat (4) tick();

    wr(0, 176, 32'h0BADF00D, 4'hF); tick();
    rd(0, 1200); tick();
    wr(1, 1200, 32'hFFFFFFFF, 4'hF); tick();
    rd(0, 176); rd(1, 1200); tick();
    repeat (4) tick();

    for (int p = 0; p < 4; p++)
      check({pn[p], "_drain"}, exq[p].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
